nox_mem_arbiter: RTL and testbench
==================================

Name: nox_mem_arbiter

Overview:
Round-robin arbiter that shares one single-port, pipelined memory channel between N_REQ requesters, e.g. the nox instruction-fetch and LSU ports ahead of a single on-chip RAM.
The grant is locked to one owner for a bounded burst.
Responses carry no ID, so the grant only moves on once all outstanding responses have drained, and responses are routed to the owner of record.
A sticky protocol-error flag reports spurious responses.

Parameters:
N_REQ, 2, number of requesters (2..8)
ADDR_WIDTH, 32, request address width
DATA_WIDTH, 32, data width; strobe width = DATA_WIDTH/8
MAX_OUTST, 4, max requests accepted but not yet answered (1..15)
BURST_MAX, 8, max requests issued per grant before a forced hand-over (1..255)

Ports:
clk  in  1  single clock, all logic rising-edge
arst  in  1  asynchronous reset, active-low
req_valid_i  in  N_REQ  request valid per requester
req_ready_o  out  N_REQ  request accepted per requester
req_addr_i  in  N_REQ*ADDR_WIDTH  requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_we_i  in  N_REQ  1 = write
req_wdata_i  in  N_REQ*DATA_WIDTH  write data, same slicing
req_wstrb_i  in  N_REQ*DATA_WIDTH/8  byte strobes, same slicing
resp_valid_o  out  N_REQ  response strobe to the owner of record
resp_data_o  out  DATA_WIDTH  shared read data
resp_err_o  out  1  shared error, valid with resp_valid_o
mem_valid_o  out  1  request to memory
mem_ready_i  in  1  memory accepts request
mem_addr_o / mem_we_o / mem_wdata_o / mem_wstrb_o  out  ADDR_WIDTH / 1 / DATA_WIDTH / DATA_WIDTH/8  muxed owner payload
mem_resp_valid_i  in  1  memory response, in order, one per accepted request
mem_resp_data_i  in  DATA_WIDTH  response data
mem_resp_err_i  in  1  response error
owner_o  out  $clog2(N_REQ) (min 1)  current or last owner
busy_o  out  1  state != IDLE
protocol_err_o  out  1  sticky spurious-response flag

Behaviour:
Reset (arst low, asynchronous):
- State IDLE; rr_ptr = N_REQ-1, so requester 0 wins first; owner = 0.
- outst = 0, burst = 0, protocol_err_o = 0.
- All valid/ready outputs 0; data outputs 0.
- Asserting reset mid-transaction abandons it; no response is delivered afterwards.

IDLE:
- If any req_valid_i is set, pick the first set bit searching (rr_ptr+1) mod N_REQ upward with wrap.
- Latch owner, clear burst, go to BUSY.
- Arbitration costs 1 cycle; no request is issued in IDLE.

BUSY:
- can_issue = req_valid_i[owner] && outst < MAX_OUTST && burst < BURST_MAX.
- mem_valid_o = can_issue, combinational.
- mem_* payload = owner's slice.
- req_ready_o[owner] = can_issue && mem_ready_i; all other ready bits are 0.
- On accept: outst += 1 and burst += 1.
- Go to DRAIN when !req_valid_i[owner] in a non-accept cycle, or when burst reaches BURST_MAX (the cycle after the BURST_MAX-th accept).

DRAIN:
- No issue.
- Go to IDLE in the cycle where next outst == 0, or immediately if outst is already 0. Then set rr_ptr = owner.
- Minimum grant turnaround is therefore IDLE + DRAIN = 2 idle cycles.

Responses (any state):
- If mem_resp_valid_i && outst > 0: resp_valid_o[owner] = 1 and outst -= 1, combinational with 0 latency.
- resp_data_o / resp_err_o pass through mem_resp_data_i / mem_resp_err_i.
- Accept and response in the same cycle leave outst unchanged.
- If mem_resp_valid_i && outst == 0: the response is dropped, resp_valid_o stays 0, and protocol_err_o is set to 1 until reset.

Requester rules:
- Payload must be stable while valid && !ready.
- Dropping valid releases the grant.
- Requests are never reordered. Responses return in issue order.

Counters:
- outst width is 4 bits and never exceeds MAX_OUTST.
- burst saturates at BURST_MAX.
- No wrap is possible by construction.

Test Plan:
1. Reset then req_valid_i = 2'b11 held, mem_ready_i = 1, memory answers 1 cycle after each accept → req 0 is granted first and gets 8 accepts (BURST_MAX); DRAIN; req 1 is then granted. Observe owner_o 0→1→0 alternating and no accepts during IDLE/DRAIN cycles.
2. Req 0 issues 4 reads (MAX_OUTST=4) with responses withheld → mem_valid_o drops after the 4th accept. Release one response (data 0xDEADBEEF) → resp_valid_o = 2'b01 with 0xDEADBEEF, and exactly one more accept follows.
3. Req 0 drops valid while 3 responses are outstanding, and req 1 is asserted → owner stays 0 until the 3rd response; req 1 gets its first accept exactly 2 cycles after it.
4. Same-cycle accept and response with outst = 2 → outst stays 2, checked by a subsequent exact count of 2 remaining responses.
5. mem_resp_valid_i pulsed while in IDLE with outst = 0 → no resp_valid_o, protocol_err_o = 1 and stays high; cleared only by arst.
6. arst asserted low mid-burst with outst = 3 → all outputs 0 asynchronously. After release, req_valid_i = 2'b10 gives req 1 the grant and outst starts from 0.

Source files
------------

// File: rtl/nox_mem_arbiter.sv
// Round-robin arbiter sharing one pipelined memory channel between N_REQ requesters.
// A grant is held for a bounded burst. Because responses carry no ID, the grant only
// moves once every outstanding response has drained. Responses go to the owner of record.
module nox_mem_arbiter #(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_OUTST  = 4,
  parameter int unsigned BURST_MAX  = 8
) (
  input  logic                                        clk,
  input  logic                                        arst,
  input  logic [N_REQ-1:0]                            req_valid_i,
  output logic [N_REQ-1:0]                            req_ready_o,
  input  logic [N_REQ*ADDR_WIDTH-1:0]                 req_addr_i,
  input  logic [N_REQ-1:0]                            req_we_i,
  input  logic [N_REQ*DATA_WIDTH-1:0]                 req_wdata_i,
  input  logic [N_REQ*(DATA_WIDTH/8)-1:0]             req_wstrb_i,
  output logic [N_REQ-1:0]                            resp_valid_o,
  output logic [DATA_WIDTH-1:0]                       resp_data_o,
  output logic                                        resp_err_o,
  output logic                                        mem_valid_o,
  input  logic                                        mem_ready_i,
  output logic [ADDR_WIDTH-1:0]                       mem_addr_o,
  output logic                                        mem_we_o,
  output logic [DATA_WIDTH-1:0]                       mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0]                     mem_wstrb_o,
  input  logic                                        mem_resp_valid_i,
  input  logic [DATA_WIDTH-1:0]                       mem_resp_data_i,
  input  logic                                        mem_resp_err_i,
  output logic [(N_REQ > 1 ? $clog2(N_REQ) : 1)-1:0]  owner_o,
  output logic                                        busy_o,
  output logic                                        protocol_err_o
);

  localparam int unsigned OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned SW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {StIdle, StBusy, StDrain} state_e;

  state_e          state_q;
  logic [OW-1:0]   owner_q, rr_ptr_q;
  logic [3:0]      outst_q, outst_d;
  logic [7:0]      burst_q;
  logic            perr_q;

  logic [OW-1:0]   grant_idx, cand;
  logic            grant_found;
  logic            can_issue, accept, resp_ok, spurious;

  logic [ADDR_WIDTH-1:0] addr_arr  [N_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [N_REQ];
  logic [SW-1:0]         wstrb_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign addr_arr[g]  = req_addr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = req_wdata_i[g*DATA_WIDTH +: DATA_WIDTH];
    assign wstrb_arr[g] = req_wstrb_i[g*SW +: SW];
  end

  // Round-robin search starting just after the last owner, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = rr_ptr_q;
    cand        = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = OW'((32'(rr_ptr_q) + i) % N_REQ);
      if (!grant_found && req_valid_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Issue/response qualification and the outstanding-count update.
  always_comb begin
    can_issue = (state_q == StBusy) && req_valid_i[owner_q] &&
                (outst_q < 4'(MAX_OUTST)) && (burst_q < 8'(BURST_MAX));
    accept    = can_issue && mem_ready_i;
    resp_ok   = mem_resp_valid_i && (outst_q != 4'd0);
    spurious  = mem_resp_valid_i && (outst_q == 4'd0);
    outst_d   = outst_q + {3'b000, accept} - {3'b000, resp_ok};
  end

  // Channel outputs; payload and response data read as zero when not qualified.
  always_comb begin
    mem_valid_o  = can_issue;
    mem_addr_o   = can_issue ? addr_arr[owner_q]  : '0;
    mem_we_o     = can_issue ? req_we_i[owner_q]  : 1'b0;
    mem_wdata_o  = can_issue ? wdata_arr[owner_q] : '0;
    mem_wstrb_o  = can_issue ? wstrb_arr[owner_q] : '0;
    req_ready_o  = '0;
    if (accept) req_ready_o[owner_q] = 1'b1;
    resp_valid_o = '0;
    if (resp_ok) resp_valid_o[owner_q] = 1'b1;
    resp_data_o  = resp_ok ? mem_resp_data_i : '0;
    resp_err_o   = resp_ok && mem_resp_err_i;
  end

  // Grant FSM, counters and the sticky spurious-response flag.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      rr_ptr_q <= OW'(N_REQ - 1);
      outst_q  <= 4'd0;
      burst_q  <= 8'd0;
      perr_q   <= 1'b0;
    end else begin
      outst_q <= outst_d;
      if (spurious) perr_q <= 1'b1;
      case (state_q)
        StIdle: begin
          if (grant_found) begin
            owner_q <= grant_idx;
            burst_q <= 8'd0;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (accept) begin
            burst_q <= burst_q + 8'd1;
          end else if (!req_valid_i[owner_q] || (burst_q >= 8'(BURST_MAX))) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          // Hand over only once nothing is in flight, so responses cannot be misrouted.
          if (outst_d == 4'd0) begin
            state_q  <= StIdle;
            rr_ptr_q <= owner_q;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign owner_o        = owner_q;
  assign busy_o         = (state_q != StIdle);
  assign protocol_err_o = perr_q;

endmodule

// File: tb/tb_nox_mem_arbiter.sv
// Bench for nox_mem_arbiter: directed requester traffic, a small in-order memory model,
// and a scoreboard of expected responses drained by an independent monitor.
module tb_nox_mem_arbiter;

  localparam int unsigned N = 2, AW = 32, DW = 32, SW = 4;

  logic            clk = 1'b0;
  logic            arst;
  logic [N-1:0]    req_valid_i, req_ready_o, req_we_i, resp_valid_o;
  logic [N*AW-1:0] req_addr_i;
  logic [N*DW-1:0] req_wdata_i;
  logic [N*SW-1:0] req_wstrb_i;
  logic [DW-1:0]   resp_data_o, mem_wdata_o, mem_resp_data_i;
  logic            resp_err_o, mem_valid_o, mem_ready_i, mem_we_o;
  logic [AW-1:0]   mem_addr_o;
  logic [SW-1:0]   mem_wstrb_o;
  logic            mem_resp_valid_i, mem_resp_err_i;
  logic [0:0]      owner_o;
  logic            busy_o, protocol_err_o;

  always #5 clk = ~clk;

  nox_mem_arbiter #(
    .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTST(4), .BURST_MAX(8)
  ) dut (
    .clk(clk), .arst(arst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_we_i(req_we_i), .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
    .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_data_i(mem_resp_data_i),
    .mem_resp_err_i(mem_resp_err_i),
    .owner_o(owner_o), .busy_o(busy_o), .protocol_err_o(protocol_err_o)
  );

  typedef struct {int id; logic [31:0] data;} exp_t;

  exp_t        sb[$];
  logic [31:0] pend[$];
  exp_t        mon_e;
  int          checks = 0, errors = 0;
  int          cnt[N], acc_cnt[N];
  logic [31:0] addr[N];
  logic [N-1:0] we_sel;
  int          cyc = 0, resp_cnt = 0, rel_cnt = 0;
  int          last_resp_cyc, first_acc1_cyc;
  logic [0:0]  own_at_resp;
  bit          auto_resp = 1'b0, spur = 1'b0;
  logic [N-1:0] acc, rv_s;
  logic        macc, mv, mwe;
  logic [31:0] maddr, mwdata, last_rdata;
  logic [3:0]  mstrb;
  logic [N-1:0] last_rv;
  int          trace[$], run_id[$], run_len[$];
  int          gap, prev, both, min_gap;
  int          exp_ids[3] = '{0, 1, 0};

  // Memory model response: address-derived, folded with write payload for writes.
  function automatic logic [31:0] rdata(input logic [31:0] a, input logic w,
                                        input logic [31:0] wd, input logic [3:0] st);
    return a ^ 32'h5555_0000 ^ (w ? (wd ^ {28'h0, st}) : 32'h0);
  endfunction

  function automatic logic [3:0] strb_of(input int i);
    return (i == 0) ? 4'hF : 4'h3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_valid_i[i]          = (cnt[i] > 0);
      req_addr_i[i*AW +: AW]  = addr[i];
      req_we_i[i]             = we_sel[i];
      req_wdata_i[i*DW +: DW] = addr[i] + 32'h1111_0000;
      req_wstrb_i[i*SW +: SW] = strb_of(i);
    end
  endtask

  // One clock: sample handshakes at negedge, then advance requesters and memory model.
  task automatic tick();
    exp_t te;
    @(negedge clk);
    cyc++;
    acc = req_valid_i & req_ready_o;
    macc = mem_valid_o & mem_ready_i;
    mv = mem_valid_o;
    maddr = mem_addr_o; mwe = mem_we_o; mwdata = mem_wdata_o; mstrb = mem_wstrb_o;
    rv_s = resp_valid_o;
    if (rv_s != '0) begin
      resp_cnt++;
      last_resp_cyc = cyc;
      own_at_resp = owner_o;
      last_rdata = resp_data_o;
      last_rv = rv_s;
    end
    if (acc[1] && first_acc1_cyc < 0) first_acc1_cyc = cyc;
    @(posedge clk);
    #1;
    mem_resp_valid_i = 1'b0;
    mem_resp_data_i  = '0;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        te.id = i;
        te.data = rdata(addr[i], we_sel[i], addr[i] + 32'h1111_0000, strb_of(i));
        sb.push_back(te);
        acc_cnt[i]++;
        addr[i] += 32'd4;
        cnt[i]--;
      end
    end
    if (macc) pend.push_back(rdata(maddr, mwe, mwdata, mstrb));
    if (pend.size() > 0 && (auto_resp || rel_cnt > 0)) begin
      mem_resp_valid_i = 1'b1;
      mem_resp_data_i  = pend.pop_front();
      if (!auto_resp) rel_cnt--;
    end
    if (spur) begin
      mem_resp_valid_i = 1'b1;
      mem_resp_data_i  = 32'h0BAD_0BAD;
      spur = 1'b0;
    end
    drive_reqs();
  endtask

  task automatic wait_acc(input int r, input int n, input string name);
    int k = 0;
    while (acc_cnt[r] < n && k < 50) begin
      tick();
      k++;
    end
    chk(name, 32'(acc_cnt[r] >= n), 32'd1);
  endtask

  task automatic drain(input string name);
    int k = 0;
    auto_resp = 1'b1;
    while ((busy_o || sb.size() != 0 || pend.size() != 0) && k < 100) begin
      tick();
      k++;
    end
    chk(name, 32'(k < 100), 32'd1);
  endtask

  // Scoreboard monitor: every delivered response must match the oldest expectation.
  always @(negedge clk) begin
    if (arst === 1'b1 && resp_valid_o !== '0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected: got resp_valid %b with none pending", resp_valid_o);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_owner", 32'(resp_valid_o), 32'd1 << mon_e.id);
        chk("resp_data", resp_data_o, mon_e.data);
        chk("resp_err", 32'(resp_err_o), 32'd0);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    arst = 1'b0;
    cnt = '{0, 0}; acc_cnt = '{0, 0};
    addr = '{32'h0000_1000, 32'h0000_2000};
    we_sel = 2'b10;
    mem_ready_i = 1'b1; mem_resp_valid_i = 1'b0; mem_resp_data_i = '0; mem_resp_err_i = 1'b0;
    first_acc1_cyc = -1; last_resp_cyc = 0;
    drive_reqs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_owner", 32'(owner_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_perr", 32'(protocol_err_o), 32'd0);
    chk("rst_mem_valid", 32'(mem_valid_o), 32'd0);
    chk("rst_ready", 32'(req_ready_o), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);
    arst = 1'b1;

    // 1: both requesters held; bursts of 8 alternate 0,1,0 with gaps between grants.
    auto_resp = 1'b1;
    cnt = '{16, 8};
    drive_reqs();
    begin
      int k = 0;
      while ((cnt[0] > 0 || cnt[1] > 0) && k < 200) begin
        tick();
        trace.push_back(acc == 2'b01 ? 0 : acc == 2'b10 ? 1 : acc == 2'b00 ? -1 : 9);
        k++;
      end
      chk("t1_bound", 32'(k < 200), 32'd1);
    end
    drain("t1_drain");
    prev = -1; gap = 100; both = 0; min_gap = 100;
    foreach (trace[j]) begin
      if (trace[j] == 9) both++;
      else if (trace[j] >= 0) begin
        if (prev == trace[j] && gap == 0) run_len[run_len.size()-1]++;
        else begin
          if (run_id.size() > 0 && gap < min_gap) min_gap = gap;
          run_id.push_back(trace[j]);
          run_len.push_back(1);
        end
        gap = 0;
        prev = trace[j];
      end else gap++;
    end
    chk("t1_both_ready", 32'(both), 32'd0);
    chk("t1_run_count", 32'(run_id.size()), 32'd3);
    for (int j = 0; j < 3; j++) begin
      chk("t1_run_owner", (j < run_id.size()) ? 32'(run_id[j]) : 32'hFFFF, 32'(exp_ids[j]));
      chk("t1_run_len", (j < run_len.size()) ? 32'(run_len[j]) : 32'hFFFF, 32'd8);
    end
    chk("t1_gap_ge2", 32'(min_gap >= 2), 32'd1);
    chk("t1_last_owner", 32'(owner_o), 32'd0);

    // 2: outstanding limit of 4, one released response lets exactly one more through.
    acc_cnt = '{0, 0}; auto_resp = 1'b0; rel_cnt = 0;
    addr[0] = 32'h8BF8_BEEF; we_sel = 2'b00; cnt[0] = 6;
    drive_reqs();
    wait_acc(0, 4, "t2_four_acc");
    repeat (3) tick();
    chk("t2_acc_stall", 32'(acc_cnt[0]), 32'd4);
    chk("t2_mem_valid_low", 32'(mv), 32'd0);
    resp_cnt = 0; rel_cnt = 1;
    repeat (5) tick();
    chk("t2_one_more", 32'(acc_cnt[0]), 32'd5);
    chk("t2_resp_count", 32'(resp_cnt), 32'd1);
    chk("t2_resp_vec", 32'(last_rv), 32'd1);
    chk("t2_resp_data", last_rdata, 32'hDEAD_BEEF);
    cnt[0] = 0;
    drive_reqs();
    drain("t2_drain");

    // 3: owner holds until its 3rd response; requester 1 accepted exactly 2 cycles later.
    acc_cnt = '{0, 0}; auto_resp = 1'b0; rel_cnt = 0;
    addr[0] = 32'h0000_3000; cnt[0] = 3;
    drive_reqs();
    wait_acc(0, 3, "t3_three_acc");
    addr[1] = 32'h0000_4000; cnt[1] = 2; first_acc1_cyc = -1;
    drive_reqs();
    repeat (4) tick();
    chk("t3_owner_hold", 32'(owner_o), 32'd0);
    chk("t3_no_acc1", 32'(acc_cnt[1]), 32'd0);
    resp_cnt = 0; rel_cnt = 3;
    wait_acc(1, 1, "t3_acc1");
    chk("t3_resp_count", 32'(resp_cnt), 32'd3);
    chk("t3_owner_at_resp", 32'(own_at_resp), 32'd0);
    chk("t3_turnaround", 32'(first_acc1_cyc - last_resp_cyc), 32'd2);
    chk("t3_owner_new", 32'(owner_o), 32'd1);
    drain("t3_drain");

    // 4: accept and response in the same cycle with 2 outstanding.
    acc_cnt = '{0, 0}; auto_resp = 1'b0; rel_cnt = 0;
    addr[0] = 32'h0000_5000; cnt[0] = 3;
    drive_reqs();
    wait_acc(0, 2, "t4_two_acc");
    mem_resp_valid_i = 1'b1;
    mem_resp_data_i = pend.pop_front();
    tick();
    chk("t4_same_acc", 32'(acc[0]), 32'd1);
    chk("t4_same_resp", 32'(rv_s), 32'd1);
    resp_cnt = 0; auto_resp = 1'b1;
    repeat (8) tick();
    chk("t4_remaining", 32'(resp_cnt), 32'd2);
    chk("t4_idle", 32'(busy_o), 32'd0);

    // 5: spurious response in IDLE is dropped and latches the sticky flag.
    chk("t5_perr_before", 32'(protocol_err_o), 32'd0);
    spur = 1'b1;
    tick();
    tick();
    chk("t5_no_resp", 32'(rv_s), 32'd0);
    chk("t5_perr_set", 32'(protocol_err_o), 32'd1);
    repeat (5) tick();
    chk("t5_perr_sticky", 32'(protocol_err_o), 32'd1);

    // 6: asynchronous reset with 3 outstanding, then a fresh grant to requester 1.
    acc_cnt = '{0, 0}; auto_resp = 1'b0; rel_cnt = 0;
    addr[0] = 32'h0000_6000; cnt[0] = 10;
    drive_reqs();
    wait_acc(0, 3, "t6_three_acc");
    #2;
    arst = 1'b0;
    #1;
    chk("t6_mem_valid", 32'(mem_valid_o), 32'd0);
    chk("t6_ready", 32'(req_ready_o), 32'd0);
    chk("t6_resp_valid", 32'(resp_valid_o), 32'd0);
    chk("t6_busy", 32'(busy_o), 32'd0);
    chk("t6_owner", 32'(owner_o), 32'd0);
    chk("t6_perr", 32'(protocol_err_o), 32'd0);
    chk("t6_mem_addr", mem_addr_o, 32'd0);
    sb.delete();
    pend.delete();
    cnt = '{0, 10}; addr[1] = 32'h0000_7000; we_sel = 2'b10;
    mem_resp_valid_i = 1'b0;
    drive_reqs();
    @(posedge clk);
    #1;
    arst = 1'b1;
    acc_cnt = '{0, 0};
    wait_acc(1, 4, "t6_four_acc");
    repeat (3) tick();
    chk("t6_acc_limit", 32'(acc_cnt[1]), 32'd4);
    chk("t6_owner_new", 32'(owner_o), 32'd1);
    chk("t6_stalled", 32'(mv), 32'd0);
    cnt[1] = 0;
    drive_reqs();
    drain("t6_drain");

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
